vga_text_feeder: RTL and testbench
==================================

// Module: vga_text_feeder
// PURPOSE
//  Wishbone-attached text sequencer placed directly upstream of the VGA character controller.
//  Buffers CPU-written ASCII bytes in a FIFO, tracks a pixel-unit text cursor, and presents
//  one {char, row/col} pair at a time to the controller's ascii/position registers.
//  Paces output so each glyph stays presented for a programmable minimum time.
//  Handles control codes: LF 0x0A, CR 0x0D and BS 0x08.
// PARAMETERS
//  FIFO_DEPTH   16        char FIFO entries (power of 2)
//  CHAR_W       8         glyph width in pixels; column step
//  CHAR_H       8         glyph height in pixels; row step
//  H_ACTIVE     640       visible columns; column wrap limit
//  V_ACTIVE     480       visible rows; row wrap limit
//  PACE_CYCLES  1_000_000 minimum i_clk cycles between successive char presentations
// PORTS
//  i_clk         in   1   system clock
//  i_rst         in   1   reset, synchronous, active-high
//  i_wb_adr      in   6   word address; [5:2] selects the register
//  i_wb_dat      in   32  write data
//  i_wb_sel      in   4   byte selects
//  i_wb_we       in   1   write enable
//  i_wb_cyc      in   1   bus cycle
//  i_wb_stb      in   1   strobe
//  o_wb_dat      out  32  read data (registered)
//  o_wb_ack      out  1   single-cycle ack
//  o_char_valid  out  1   char/position valid toward the controller
//  o_char        out  8   ASCII code
//  o_row_col     out  20  {row[9:0], col[9:0]}; top-left pixel of the glyph
//  i_char_ready  in   1   controller has latched the char
//  o_irq         out  1   low-water interrupt (only with VGA_FEEDER_IRQ_EN)
// BEHAVIOUR
//  Reset: o_wb_ack=0, o_wb_dat=0, o_char_valid=0, o_char=0, o_row_col=0, FIFO empty,
//   cursor=(0,0), enable=0, overflow=0, pace counter=0, FSM=IDLE, o_irq=0.
//  WB ack: o_wb_ack <= cyc & stb & !o_wb_ack. Reads and writes act on the cycle ack is
//   registered. Read data is valid with ack.
//  Register map, by adr[5:2]:
//   0 DATA:   W, sel[0] pushes dat[7:0]. R returns the last presented char.
//   1 CTRL:   bit0 enable (R/W).
//             bit1 clear: self-clearing; flushes FIFO, homes cursor, FSM->IDLE, valid->0.
//             bit2: W1C overflow.
//   2 STATUS: R only. [4:0] level, [5] empty, [6] full, [7] overflow (sticky), [8] busy (FSM!=IDLE).
//   3 CURSOR: R/W {row,col} in bits [19:0]; takes effect for the next FETCH.
//  FIFO push on full: byte dropped, overflow set. A push while full with a same-cycle pop is
//   still dropped, because fullness is judged before the pop.
//  FSM:
//   IDLE->FETCH:    enable & !empty.
//   FETCH:          pops 1 byte (1 cycle).
//     Printable:    latch o_char and o_row_col = cursor, ->PRESENT.
//     LF:           col=0, row+=CHAR_H.
//     CR:           col=0.
//     BS:           col-=CHAR_W, saturating at 0.
//     After LF/CR/BS: ->IDLE, and nothing is presented.
//   PRESENT:        o_char_valid=1, held stable until i_char_ready.
//                   On the handshake: advance the cursor, load the pace counter, ->HOLD.
//   HOLD:           counts PACE_CYCLES-1 down to 0, then ->IDLE.
//  Throughput: worst case 1 char per PACE_CYCLES+2 cycles.
//  Cursor advance: col+=CHAR_W.
//   If col >= H_ACTIVE: col=0, row+=CHAR_H.
//   If row >= V_ACTIVE: row=0 (wraps to top).
//   Arithmetic is 10-bit; the compares happen before truncation.
//  Enable deasserted mid-operation: the current PRESENT/HOLD completes, then the FSM parks in IDLE.
//  Clear beats everything, including a same-cycle DATA push (the push is dropped, no overflow).
//  CURSOR write during PRESENT: o_row_col is unchanged. The advance on handshake uses the new value.
//  i_rst mid-operation: everything returns to the reset values above on the next edge.
// CONFIGURATION
//  VGA_FEEDER_IRQ_EN defined:
//   Adds the o_irq port, CTRL bit3 irq_en and STATUS bit9 irq_pend.
//   irq_pend sets when level falls from >FIFO_DEPTH/4 to <=FIFO_DEPTH/4.
//   W1C via STATUS bit9. o_irq = irq_pend & irq_en.
//  VGA_FEEDER_IRQ_EN undefined: no o_irq port, the IRQ bits read 0, and writes to them are ignored.
// STRUCTURE
//  vga_pkg: register offsets, CTRL/STATUS bit indices, control-code constants,
//   typedef enum {IDLE,FETCH,PRESENT,HOLD} feeder_state_t.
//  Sub-module vga_char_fifo: sync FIFO with push/pop/level/full/empty, same clock/reset.
// TESTING
//  Write 'A' to DATA, enable=1, ready tied 1 -> valid pulses with char 0x41, row_col=0x00000;
//   CURSOR reads 0x00008.
//  CURSOR=(0,632), push 'B','C' -> 'B' at col 632; 'C' at row 8, col 0 (0x02000).
//  CURSOR=(472,0), push LF -> no valid; CURSOR reads (0,0).
//  Enable=0, push 17 bytes -> STATUS level=16, full=1, overflow=1;
//   W1C bit2 -> overflow=0.
//  PACE_CYCLES=4, push 'X','Y' with ready=1 -> valid edges exactly 6 cycles apart.
//  Hold ready=0 in PRESENT, write CTRL.clear -> valid drops next cycle; level=0; CURSOR=0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - register map, bit indices, control codes and FSM states for the VGA text feeder
`timescale 1ns/1ps
package vga_pkg;

    // Register offsets, selected by wishbone adr[5:2]
    localparam logic [3:0] REG_DATA   = 4'd0;
    localparam logic [3:0] REG_CTRL   = 4'd1;
    localparam logic [3:0] REG_STATUS = 4'd2;
    localparam logic [3:0] REG_CURSOR = 4'd3;

    // CTRL bit indices
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_OVF_W1C = 2;
    localparam int CTRL_IRQ_EN  = 3;

    // STATUS bit indices (level occupies [4:0])
    localparam int STAT_EMPTY = 5;
    localparam int STAT_FULL  = 6;
    localparam int STAT_OVF   = 7;
    localparam int STAT_BUSY  = 8;
    localparam int STAT_IRQ   = 9;

    // Control codes acted on instead of being presented
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HOLD} feeder_state_t;

    // True for bytes that move the cursor rather than produce a glyph
    function automatic logic is_ctrl_code(input logic [7:0] c);
        return (c == ASCII_LF) || (c == ASCII_CR) || (c == ASCII_BS);
    endfunction

endpackage

// File: rtl/vga_char_fifo.sv
// rtl/vga_char_fifo.sv - synchronous character FIFO with level, full and empty flags
`timescale 1ns/1ps
module vga_char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    // Fullness is judged on the registered level, so a push while full is dropped even with a pop
    assign o_full  = (level_q == (AW+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;
    assign o_data  = mem_q[rd_ptr_q];
    assign o_level = level_q;

    // Pointer/level bookkeeping; flush discards contents without touching storage
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/vga_text_feeder.sv
// rtl/vga_text_feeder.sv - wishbone text sequencer feeding the VGA character controller (option: VGA_FEEDER_IRQ_EN)
`timescale 1ns/1ps
module vga_text_feeder
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int CHAR_W      = 8,
    parameter int CHAR_H      = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PACE_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_char_valid,
    output logic [7:0]  o_char,
    output logic [19:0] o_row_col,
    input  logic        i_char_ready
`ifdef VGA_FEEDER_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(PACE_CYCLES - 1);

    feeder_state_t     state_q, state_d;
    logic              wb_ack_q, wb_ack_d;
    logic [31:0]       wb_dat_q, wb_dat_d;
    logic              enable_q, enable_d;
    logic              ovf_q, ovf_d;
    logic [9:0]        row_q, row_d;
    logic [9:0]        col_q, col_d;
    logic [7:0]        char_q, char_d;
    logic [19:0]       rc_q, rc_d;
    logic [PACE_W-1:0] pace_q, pace_d;

    logic              bus_act, wr_act, rd_act;
    logic [3:0]        reg_sel;
    logic              ctrl_wr, cursor_wr, clear, push;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;
    logic              busy;
    logic [19:0]       cursor_wr_val;
    logic [31:0]       rd_mux;
    logic              irq_en_bit, irq_pend_bit;
    logic              unused_ok;

    assign unused_ok = ^{i_wb_adr[1:0], i_wb_dat[31:20], i_wb_sel[3]};

    // A bus access takes effect on the cycle its ack is being registered
    assign bus_act   = i_wb_cyc & i_wb_stb & ~wb_ack_q;
    assign wr_act    = bus_act & i_wb_we;
    assign rd_act    = bus_act & ~i_wb_we;
    assign reg_sel   = i_wb_adr[5:2];
    assign ctrl_wr   = wr_act & (reg_sel == REG_CTRL) & i_wb_sel[0];
    assign cursor_wr = wr_act & (reg_sel == REG_CURSOR);
    assign clear     = ctrl_wr & i_wb_dat[CTRL_CLEAR];
    assign push      = wr_act & (reg_sel == REG_DATA) & i_wb_sel[0] & ~clear;

    vga_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (clear),
        .i_push  (push),
        .i_data  (i_wb_dat[7:0]),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_level (fifo_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Row step with wrap to the top; compare is done at 11 bits before truncation
    function automatic logic [9:0] step_row(input logic [9:0] r);
        logic [10:0] s;
        s = {1'b0, r} + 11'(CHAR_H);
        return (s >= 11'(V_ACTIVE)) ? 10'd0 : (r + 10'(CHAR_H));
    endfunction

    // Cursor advance after a presented glyph: {row, col}
    function automatic logic [19:0] advance(input logic [9:0] r, input logic [9:0] c);
        logic [10:0] s;
        s = {1'b0, c} + 11'(CHAR_W);
        if (s >= 11'(H_ACTIVE)) return {step_row(r), 10'd0};
        return {r, c + 10'(CHAR_W)};
    endfunction

`ifdef VGA_FEEDER_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_pend_q, irq_pend_d;
    logic [LVL_W-1:0] prev_level_q;

    // Low-water interrupt: latch a downward crossing of DEPTH/4, software clears via STATUS W1C
    always_comb begin
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        if (ctrl_wr) irq_en_d = i_wb_dat[CTRL_IRQ_EN];
        if (wr_act && (reg_sel == REG_STATUS) && i_wb_sel[1] && i_wb_dat[STAT_IRQ]) irq_pend_d = 1'b0;
        if ((prev_level_q > LVL_W'(FIFO_DEPTH / 4)) && (fifo_level <= LVL_W'(FIFO_DEPTH / 4)))
            irq_pend_d = 1'b1;
    end

    // IRQ state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_en_q     <= 1'b0;
            irq_pend_q   <= 1'b0;
            prev_level_q <= '0;
        end else begin
            irq_en_q     <= irq_en_d;
            irq_pend_q   <= irq_pend_d;
            prev_level_q <= fifo_level;
        end
    end

    assign irq_en_bit   = irq_en_q;
    assign irq_pend_bit = irq_pend_q;
    assign o_irq        = irq_pend_q & irq_en_q;
`else
    assign irq_en_bit   = 1'b0;
    assign irq_pend_bit = 1'b0;
`endif

    // Register read multiplexer
    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_DATA:   rd_mux = {24'd0, char_q};
            REG_CTRL: begin
                rd_mux[CTRL_ENABLE] = enable_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_bit;
            end
            REG_STATUS: begin
                rd_mux[4:0]        = 5'(fifo_level);
                rd_mux[STAT_EMPTY] = fifo_empty;
                rd_mux[STAT_FULL]  = fifo_full;
                rd_mux[STAT_OVF]   = ovf_q;
                rd_mux[STAT_BUSY]  = busy;
                rd_mux[STAT_IRQ]   = irq_pend_bit;
            end
            REG_CURSOR: rd_mux = {12'd0, row_q, col_q};
            default:    rd_mux = 32'd0;
        endcase
    end

    // Byte-lane merge for CURSOR writes
    always_comb begin
        cursor_wr_val = {row_q, col_q};
        if (i_wb_sel[0]) cursor_wr_val[7:0]   = i_wb_dat[7:0];
        if (i_wb_sel[1]) cursor_wr_val[15:8]  = i_wb_dat[15:8];
        if (i_wb_sel[2]) cursor_wr_val[19:16] = i_wb_dat[19:16];
    end

    // FSM next state; clear overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_q && !fifo_empty) state_d = FETCH;
            FETCH:   state_d = is_ctrl_code(fifo_rdata) ? IDLE : PRESENT;
            PRESENT: if (i_char_ready) state_d = HOLD;
            HOLD:    if (pace_q <= PACE_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        o_char_valid = (state_q == PRESENT);
        fifo_pop     = (state_q == FETCH);
        busy         = (state_q != IDLE);
    end

    // Datapath: bus side effects, cursor motion, glyph latch and pacing
    always_comb begin
        wb_ack_d = i_wb_cyc & i_wb_stb & ~wb_ack_q;
        wb_dat_d = wb_dat_q;
        enable_d = enable_q;
        ovf_d    = ovf_q;
        row_d    = row_q;
        col_d    = col_q;
        char_d   = char_q;
        rc_d     = rc_q;
        pace_d   = pace_q;

        if (ctrl_wr) begin
            enable_d = i_wb_dat[CTRL_ENABLE];
            if (i_wb_dat[CTRL_OVF_W1C]) ovf_d = 1'b0;
        end
        if (push && fifo_full) ovf_d = 1'b1;

        case (state_q)
            FETCH: begin
                case (fifo_rdata)
                    ASCII_LF: begin
                        col_d = 10'd0;
                        row_d = step_row(row_q);
                    end
                    ASCII_CR: col_d = 10'd0;
                    ASCII_BS: col_d = (col_q >= 10'(CHAR_W)) ? (col_q - 10'(CHAR_W)) : 10'd0;
                    default: begin
                        char_d = fifo_rdata;
                        rc_d   = {row_q, col_q};
                    end
                endcase
            end
            PRESENT: begin
                if (i_char_ready) begin
                    {row_d, col_d} = advance(row_q, col_q);
                    pace_d         = PACE_LOAD;
                end
            end
            HOLD:    if (pace_q != '0) pace_d = pace_q - PACE_W'(1);
            default: ;
        endcase

        // Software cursor writes win over FSM motion in the same cycle
        if (cursor_wr) {row_d, col_d} = cursor_wr_val;

        if (clear) begin
            row_d  = 10'd0;
            col_d  = 10'd0;
            pace_d = '0;
        end

        if (rd_act) wb_dat_d = rd_mux;
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wb_ack_q <= 1'b0;
            wb_dat_q <= 32'd0;
            enable_q <= 1'b0;
            ovf_q    <= 1'b0;
            row_q    <= 10'd0;
            col_q    <= 10'd0;
            char_q   <= 8'd0;
            rc_q     <= 20'd0;
            pace_q   <= '0;
        end else begin
            state_q  <= state_d;
            wb_ack_q <= wb_ack_d;
            wb_dat_q <= wb_dat_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
            row_q    <= row_d;
            col_q    <= col_d;
            char_q   <= char_d;
            rc_q     <= rc_d;
            pace_q   <= pace_d;
        end
    end

    assign o_wb_ack  = wb_ack_q;
    assign o_wb_dat  = wb_dat_q;
    assign o_char    = char_q;
    assign o_row_col = rc_q;

endmodule

// File: tb/tb_vga_text_feeder.sv
// tb/tb_vga_text_feeder.sv - directed self-checking bench for vga_text_feeder
`timescale 1ns/1ps
module tb_vga_text_feeder;

    logic        clk;
    logic        rst;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        char_valid;
    logic [7:0]  char_o;
    logic [19:0] row_col;
    logic        char_ready;
`ifdef VGA_FEEDER_IRQ_EN
    logic        irq;
`endif

    int vectors;
    int miscompares;

    int cap_cnt;
    int cap_t [4];
    logic [7:0]  cap_char [4];
    logic [19:0] cap_rc [4];

    vga_text_feeder #(
        .FIFO_DEPTH  (16),
        .CHAR_W      (8),
        .CHAR_H      (8),
        .H_ACTIVE    (640),
        .V_ACTIVE    (480),
        .PACE_CYCLES (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat_w),
        .i_wb_sel     (wb_sel),
        .i_wb_we      (wb_we),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .o_wb_dat     (wb_dat_r),
        .o_wb_ack     (wb_ack),
        .o_char_valid (char_valid),
        .o_char       (char_o),
        .o_row_col    (row_col),
        .i_char_ready (char_ready)
`ifdef VGA_FEEDER_IRQ_EN
        ,
        .o_irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wb_write(input logic [3:0] idx, input logic [31:0] dat);
        bit got;
        got = 0;
        @(negedge clk);
        wb_adr = {idx, 2'b00}; wb_dat_w = dat; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin got = 1; break; end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL wb_write_timeout reg=%0d no ack within 8 cycles", idx);
        end
    endtask

    task automatic wb_read(input logic [3:0] idx, output logic [31:0] dat);
        bit got;
        got = 0;
        dat = 32'hDEAD_BEEF;
        @(negedge clk);
        wb_adr = {idx, 2'b00}; wb_sel = 4'hF; wb_we = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin got = 1; dat = wb_dat_r; break; end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL wb_read_timeout reg=%0d no ack within 8 cycles", idx);
        end
    endtask

    // Poll STATUS until FIFO empty and FSM idle
    task automatic wait_idle();
        logic [31:0] st;
        bit done;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            wb_read(4'd2, st);
            if (st[5] && !st[8]) begin done = 1; break; end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle_timeout status=0x%0h", st);
        end
    endtask

    // Record rising edges of valid over a fixed window
    task automatic capture(input int max_cyc);
        logic prev;
        cap_cnt = 0;
        prev = char_valid;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (char_valid && !prev && cap_cnt < 4) begin
                cap_t[cap_cnt]    = i;
                cap_char[cap_cnt] = char_o;
                cap_rc[cap_cnt]   = row_col;
                cap_cnt++;
            end
            prev = char_valid;
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (char_valid) begin seen = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({wb_ack, wb_dat_r, char_valid, char_o, row_col} !== 62'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got ack=%b dat=0x%0h v=%b ch=0x%0h rc=0x%0h want all 0",
                     wb_ack, wb_dat_r, char_valid, char_o, row_col);
        end
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'h20) begin miscompares++; $display("FAIL reset_status got 0x%0h want 0x20", r); end
        wb_read(4'd1, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl got 0x%0h want 0x0", r); end
        wb_read(4'd3, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_cursor got 0x%0h want 0x0", r); end
    endtask

    task automatic test_ack_pulse();
        int acks;
        acks = 0;
        @(negedge clk);
        wb_adr = {4'd2, 2'b00}; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack) acks++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        vectors++;
        if (acks !== 2) begin miscompares++; $display("FAIL ack_pulse got %0d acks want 2", acks); end
    endtask

    task automatic test_basic_char();
        logic [31:0] r;
        wb_write(4'd0, 32'h41);
        wb_write(4'd1, 32'h1);
        capture(20);
        vectors++;
        if (cap_cnt !== 1 || cap_char[0] !== 8'h41 || cap_rc[0] !== 20'h00000) begin
            miscompares++;
            $display("FAIL basic_char got n=%0d ch=0x%0h rc=0x%0h want n=1 ch=0x41 rc=0x0",
                     cap_cnt, cap_char[0], cap_rc[0]);
        end
        wb_read(4'd3, r);
        vectors++;
        if (r !== 32'h8) begin miscompares++; $display("FAIL basic_cursor got 0x%0h want 0x8", r); end
        wb_read(4'd0, r);
        vectors++;
        if (r !== 32'h41) begin miscompares++; $display("FAIL basic_data_rd got 0x%0h want 0x41", r); end
    endtask

    task automatic test_col_wrap();
        logic [31:0] r;
        wait_idle();
        wb_write(4'd1, 32'h0);
        wb_write(4'd3, 32'h278);
        wb_write(4'd0, 32'h42);
        wb_write(4'd0, 32'h43);
        wb_write(4'd1, 32'h1);
        capture(30);
        vectors++;
        if (cap_cnt !== 2 || cap_char[0] !== 8'h42 || cap_rc[0] !== 20'h00278) begin
            miscompares++;
            $display("FAIL wrap_B got n=%0d ch=0x%0h rc=0x%0h want n=2 ch=0x42 rc=0x278",
                     cap_cnt, cap_char[0], cap_rc[0]);
        end
        vectors++;
        if (cap_char[1] !== 8'h43 || cap_rc[1] !== 20'h02000) begin
            miscompares++;
            $display("FAIL wrap_C got ch=0x%0h rc=0x%0h want ch=0x43 rc=0x2000", cap_char[1], cap_rc[1]);
        end
        wb_read(4'd3, r);
        vectors++;
        if (r !== 32'h2008) begin miscompares++; $display("FAIL wrap_cursor got 0x%0h want 0x2008", r); end
    endtask

    task automatic test_lf_wrap();
        logic [31:0] r;
        wait_idle();
        wb_write(4'd1, 32'h0);
        wb_write(4'd3, 32'h76000);
        wb_write(4'd0, 32'h0A);
        wb_write(4'd1, 32'h1);
        capture(20);
        vectors++;
        if (cap_cnt !== 0) begin miscompares++; $display("FAIL lf_no_valid got %0d edges want 0", cap_cnt); end
        wb_read(4'd3, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL lf_cursor got 0x%0h want 0x0", r); end
    endtask

    task automatic test_bs_cr();
        logic [31:0] r;
        logic [7:0]  codes [3];
        logic [31:0] want  [3];
        codes[0] = 8'h08; want[0] = 32'h400C;
        codes[1] = 8'h0D; want[1] = 32'h4000;
        codes[2] = 8'h08; want[2] = 32'h4000;
        wait_idle();
        wb_write(4'd3, 32'h4014);
        for (int i = 0; i < 3; i++) begin
            wb_write(4'd0, {24'd0, codes[i]});
            wait_idle();
            wb_read(4'd3, r);
            vectors++;
            if (r !== want[i]) begin
                miscompares++;
                $display("FAIL bs_cr_step%0d got 0x%0h want 0x%0h", i, r, want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        wb_write(4'd1, 32'h0);
        for (int i = 0; i < 17; i++) wb_write(4'd0, 32'h30 + i);
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'hD0) begin miscompares++; $display("FAIL ovf_status got 0x%0h want 0xd0", r); end
        wb_write(4'd1, 32'h4);
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'h50) begin miscompares++; $display("FAIL ovf_w1c got 0x%0h want 0x50", r); end
        wb_write(4'd1, 32'h2);
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'h20) begin miscompares++; $display("FAIL ovf_clear got 0x%0h want 0x20", r); end
    endtask

    task automatic test_back_to_back();
        wb_write(4'd3, 32'h4000);
        wb_write(4'd0, 32'h58);
        wb_write(4'd0, 32'h59);
        wb_write(4'd1, 32'h1);
        capture(30);
        vectors++;
        if (cap_cnt !== 2 || (cap_t[1] - cap_t[0]) !== 6) begin
            miscompares++;
            $display("FAIL pace_gap got n=%0d gap=%0d want n=2 gap=6", cap_cnt, cap_t[1] - cap_t[0]);
        end
        vectors++;
        if (cap_char[0] !== 8'h58 || cap_char[1] !== 8'h59 || cap_rc[0] !== 20'h04000 || cap_rc[1] !== 20'h04008) begin
            miscompares++;
            $display("FAIL pace_chars got 0x%0h@0x%0h 0x%0h@0x%0h want 0x58@0x4000 0x59@0x4008",
                     cap_char[0], cap_rc[0], cap_char[1], cap_rc[1]);
        end
    endtask

    task automatic test_present_clear();
        logic [31:0] r;
        bit seen;
        wait_idle();
        char_ready = 1'b0;
        wb_write(4'd1, 32'h0);
        wb_write(4'd3, 32'h0);
        wb_write(4'd0, 32'h5A);
        wb_write(4'd0, 32'h51);
        wb_write(4'd1, 32'h1);
        wait_valid(seen);
        vectors++;
        if (!seen || char_o !== 8'h5A || row_col !== 20'h0) begin
            miscompares++;
            $display("FAIL present_Z got seen=%b ch=0x%0h rc=0x%0h want 1 0x5a 0x0", seen, char_o, row_col);
        end
        wb_write(4'd3, 32'h64);
        vectors++;
        if (char_valid !== 1'b1 || row_col !== 20'h0) begin
            miscompares++;
            $display("FAIL present_hold got v=%b rc=0x%0h want 1 0x0", char_valid, row_col);
        end
        @(negedge clk); char_ready = 1'b1;
        @(negedge clk); char_ready = 1'b0;
        wait_valid(seen);
        vectors++;
        if (!seen || char_o !== 8'h51 || row_col !== 20'h0006C) begin
            miscompares++;
            $display("FAIL present_Q got seen=%b ch=0x%0h rc=0x%0h want 1 0x51 0x6c", seen, char_o, row_col);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (char_valid !== 1'b1 || char_o !== 8'h51) begin
            miscompares++;
            $display("FAIL present_stable got v=%b ch=0x%0h want 1 0x51", char_valid, char_o);
        end
        wb_write(4'd1, 32'h3);
        vectors++;
        if (char_valid !== 1'b0) begin miscompares++; $display("FAIL clear_valid got %b want 0", char_valid); end
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'h20) begin miscompares++; $display("FAIL clear_status got 0x%0h want 0x20", r); end
        wb_read(4'd3, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL clear_cursor got 0x%0h want 0x0", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bit seen;
        wb_write(4'd0, 32'h52);
        wait_valid(seen);
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rstmid_valid got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (char_valid !== 1'b0 || char_o !== 8'h0 || row_col !== 20'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs got v=%b ch=0x%0h rc=0x%0h want 0 0 0", char_valid, char_o, row_col);
        end
        wb_read(4'd1, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL rstmid_ctrl got 0x%0h want 0x0", r); end
        wb_read(4'd2, r);
        vectors++;
        if (r !== 32'h20) begin miscompares++; $display("FAIL rstmid_status got 0x%0h want 0x20", r); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        char_ready = 1'b1;
        test_reset();
        test_ack_pulse();
        test_basic_char();
        test_col_wrap();
        test_lf_wrap();
        test_bs_cr();
        test_overflow();
        test_back_to_back();
        test_present_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
